// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared state encoding and region compare helper for the bus controller
package bus_ctrl_pkg;

  // Widest address the compare helper handles; callers zero-extend into it.
  localparam int MAX_AW = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT,
    ST_ACK  = ACK
  } state_e;

  function automatic logic region_match(input logic [MAX_AW-1:0] addr,
                                        input logic [MAX_AW-1:0] base,
                                        input logic [MAX_AW-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/bus_region_dec.sv
// rtl/bus_region_dec.sv - combinational region decode with bank overlay and read-only check
module bus_region_dec
  import bus_ctrl_pkg::*;
#(
  parameter int              AW      = 16,
  parameter int              NCS     = 8,
  parameter int              IW      = (NCS > 1) ? $clog2(NCS) : 1,
  parameter logic [NCS*AW-1:0] CS_BASE = '0,
  parameter logic [NCS*AW-1:0] CS_MASK = '0,
  parameter logic [NCS-1:0]  CS_RO   = '0,
  parameter int              OVL_SRC = 0,
  parameter int              OVL_DST = 1
) (
  input  logic [AW-1:0] ADDR,
  input  logic          RWb,
  input  logic          OVL,
  output logic          hit,
  output logic [IW-1:0] idx,
  output logic          ro_violation
);

  always_comb begin
    hit          = 1'b0;
    idx          = '0;
    ro_violation = 1'b0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NCS - 1; i >= 0; i--) begin
      if (region_match(MAX_AW'(ADDR),
                       MAX_AW'(CS_BASE[i*AW +: AW]),
                       MAX_AW'(CS_MASK[i*AW +: AW]))) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
    if (OVL && hit && (idx == IW'(OVL_SRC))) begin
      idx = IW'(OVL_DST);
    end
    ro_violation = hit && !RWb && CS_RO[idx];
  end

endmodule

// File: rtl/bus_ctrl_gen.sv
// rtl/bus_ctrl_gen.sv - bus cycle FSM: chip selects, E-clock wait states, DTAC generation
// Optional bus-error output enabled with BUSCTL_BERR_EN.
module bus_ctrl_gen
  import bus_ctrl_pkg::*;
#(
  parameter int                AW      = 16,
  parameter int                NCS     = 8,
  parameter int                WSW     = 4,
  parameter int                IW      = (NCS > 1) ? $clog2(NCS) : 1,
  parameter logic [NCS*AW-1:0]  CS_BASE = '0,
  parameter logic [NCS*AW-1:0]  CS_MASK = '0,
  parameter logic [NCS*WSW-1:0] CS_WAIT = '0,
  parameter logic [NCS-1:0]     CS_RO   = '0,
  parameter int                OVL_SRC = 0,
  parameter int                OVL_DST = 1
) (
  input  logic          SYSCLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          AS,
  input  logic [AW-1:0] ADDR,
  input  logic          RWb,
  input  logic          OVL,
  output logic [NCS-1:0] CSn,
  output logic          DTAC,
  output logic          BUSY,
`ifdef BUSCTL_BERR_EN
  output logic          BERRn,
`endif
  output logic [IW-1:0] HIT_IDX
);

  logic          dec_hit;
  logic [IW-1:0] dec_idx;
  logic          dec_ro;

  bus_region_dec #(
    .AW      (AW),
    .NCS     (NCS),
    .IW      (IW),
    .CS_BASE (CS_BASE),
    .CS_MASK (CS_MASK),
    .CS_RO   (CS_RO),
    .OVL_SRC (OVL_SRC),
    .OVL_DST (OVL_DST)
  ) u_dec (
    .ADDR         (ADDR),
    .RWb          (RWb),
    .OVL          (OVL),
    .hit          (dec_hit),
    .idx          (dec_idx),
    .ro_violation (dec_ro)
  );

  state_e         state_q, state_d;
  logic [WSW-1:0] cnt_q, cnt_d;
  logic [NCS-1:0] csn_q, csn_d;
  logic           dtac_q, dtac_d;
  logic [IW-1:0]  idx_q, idx_d;
`ifdef BUSCTL_BERR_EN
  logic           berrn_q, berrn_d;
  logic           err_q, err_d;
`endif

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      csn_q   <= '1;
      dtac_q  <= 1'b1;
      idx_q   <= '0;
`ifdef BUSCTL_BERR_EN
      berrn_q <= 1'b1;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csn_q   <= csn_d;
      dtac_q  <= dtac_d;
      idx_q   <= idx_d;
`ifdef BUSCTL_BERR_EN
      berrn_q <= berrn_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csn_d   = csn_q;
    dtac_d  = dtac_q;
    idx_d   = idx_q;
`ifdef BUSCTL_BERR_EN
    berrn_d = berrn_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        csn_d  = '1;
        dtac_d = 1'b1;
        if (!AS) begin
          state_d = ST_WAIT;
          idx_d   = dec_idx;
          // Unmapped or protected accesses get no select and a zero-wait termination.
          if (dec_hit && !dec_ro) begin
            csn_d = ~(NCS'(1) << dec_idx);
            cnt_d = CS_WAIT[dec_idx*WSW +: WSW];
          end else begin
            cnt_d = '0;
          end
`ifdef BUSCTL_BERR_EN
          err_d = !(dec_hit && !dec_ro);
`endif
        end
      end
      ST_WAIT: begin
        if (AS) begin
          state_d = ST_IDLE;
          csn_d   = '1;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
`ifdef BUSCTL_BERR_EN
          if (err_q) berrn_d = 1'b0;
          else       dtac_d  = 1'b0;
`else
          dtac_d = 1'b0;
`endif
        end else if (CE) begin
          cnt_d = cnt_q - WSW'(1);
        end
      end
      ST_ACK: begin
        if (AS) begin
          state_d = ST_IDLE;
          csn_d   = '1;
          dtac_d  = 1'b1;
`ifdef BUSCTL_BERR_EN
          berrn_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        csn_d   = '1;
        dtac_d  = 1'b1;
      end
    endcase
  end

  assign CSn     = csn_q;
  assign DTAC    = dtac_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign HIT_IDX = idx_q;
`ifdef BUSCTL_BERR_EN
  assign BERRn   = berrn_q;
`endif

endmodule
